grf_mp: RTL
===========

# grf_mp

Parametrised general register file for the single-cycle and pipelined MIPS datapaths, succeeding the fixed 32×32, two-read/one-write GRF. Adds a configurable read-port count, optional write-to-read bypass, a per-register pending scoreboard for hazard detection, and a registered write-trace port for commit logging. Sits between decode (reads, issue) and write-back (write).

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width; depth = 2**ADDR_W
- NUM_RD, 2, number of independent read ports (≥1)
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports; 0 = reads return stored value only

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; clears all state while low
- rd_addr  in  NUM_RD*ADDR_W  read addresses, port i at [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, port i at [i*DATA_W +: DATA_W]; combinational
- rd_busy  out  NUM_RD  port i's register has an outstanding producer; combinational
- we  in  1  write enable
- wa  in  ADDR_W  write address
- wd  in  DATA_W  write data
- iss_en  in  1  issue: mark iss_addr pending
- iss_addr  in  ADDR_W  destination register of issued instruction
- trace_valid  out  1  one-cycle pulse: a write committed on the previous edge
- trace_addr  out  ADDR_W  address of that write
- trace_data  out  DATA_W  data of that write

## Operation
- Storage: 2**ADDR_W registers of DATA_W bits, plus a 2**ADDR_W-bit pending scoreboard sb.
- Register 0: reads always 0; writes ignored; never pending (iss to 0 ignored); never traced.
- Write: on rising edge with we=1 and wa≠0, reg[wa] ← wd and sb[wa] ← 0.
- Issue: on rising edge with iss_en=1 and iss_addr≠0, sb[iss_addr] ← 1.
- Simultaneous issue and write to the same nonzero address: set wins, sb ends 1 (newer producer outstanding); reg[wa] still takes wd.
- Read port i, addr a = rd_addr slice i:
  - a=0: rd_data=0, rd_busy=0.
  - BYPASS=1, we=1, wa=a: rd_data=wd, rd_busy=0.
  - otherwise: rd_data=reg[a], rd_busy=sb[a].
- All read ports independent; any number may address the same register.
- Trace: on each rising edge, trace_valid ← (we && wa≠0); when set, trace_addr ← wa, trace_data ← wd; when clear, trace_addr/trace_data hold previous values.

## Timing
- Reset (reset=0, asynchronous): all registers 0, sb all 0, trace_valid=0, trace_addr=0, trace_data=0; rd_data reads 0 and rd_busy 0 immediately, without a clock edge. Writes and issues during reset are discarded. Reset released mid-operation: first edge after release acts normally.
- Read latency: 0 cycles (combinational from rd_addr, state, and, if BYPASS=1, we/wa/wd).
- Write latency: visible on rd_data the cycle after the edge (BYPASS=0) or same cycle (BYPASS=1).
- rd_busy clears the cycle the write is presented if BYPASS=1, after the edge if BYPASS=0.
- Trace latency: exactly 1 cycle after the write edge; back-to-back writes give consecutive trace pulses.
- No handshake backpressure; every request is accepted every cycle.

## Test plan
- Reset: write 0xDEADBEEF to r5, assert reset=0 between edges -> rd_data for r5 drops to 0 immediately; trace_valid=0; sb clear.
- Zero register: we=1, wa=0, wd=1; iss_en=1, iss_addr=0 -> r0 reads 0, rd_busy=0, no trace pulse.
- Write/read, BYPASS=1: we=1, wa=29, wd=2, rd_addr port0=29 same cycle -> rd_data=2 before edge, still 2 after with we=0; trace_valid=1, trace_addr=29, trace_data=2 the next cycle.
- Write/read, BYPASS=0: same stimulus -> rd_data=0 before edge, 2 after.
- Scoreboard: iss r5; next cycle rd_busy=1 on any port reading r5; write r5=3 -> busy clears per BYPASS rule; iss r5 and write r5=4 same edge -> r5 reads 4, busy stays 1.
- Multiport: NUM_RD=4, write r1=1, r2=2; ports read {1,2,1,0} -> {1,2,1,0}; back-to-back writes r3, r4 -> two consecutive trace pulses with matching addr/data.

Source files
------------

// File: rtl/grf_mp_if.sv
// grf_mp_if: bus bundle for the grf_mp register file.
//   rd_addr / rd_data / rd_busy : NUM_RD packed read ports (port i in slice i)
//   we / wa / wd                : write-back commit
//   iss_en / iss_addr           : issue, marks a destination register pending
//   trace_valid/addr/data       : registered commit trace
// master = decode/write-back side, slave = the register file.
interface grf_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     we;
    logic [ADDR_W-1:0]        wa;
    logic [DATA_W-1:0]        wd;
    logic                     iss_en;
    logic [ADDR_W-1:0]        iss_addr;
    logic                     trace_valid;
    logic [ADDR_W-1:0]        trace_addr;
    logic [DATA_W-1:0]        trace_data;

    modport master (
        output rd_addr, we, wa, wd, iss_en, iss_addr,
        input  rd_data, rd_busy, trace_valid, trace_addr, trace_data
    );

    modport slave (
        input  rd_addr, we, wa, wd, iss_en, iss_addr,
        output rd_data, rd_busy, trace_valid, trace_addr, trace_data
    );
endinterface

// File: rtl/grf_mp.sv
// grf_mp: parametrised MIPS general register file.
//   - 2**ADDR_W registers of DATA_W bits, register 0 hard-wired to zero.
//   - NUM_RD independent combinational read ports, optional same-cycle
//     write-to-read bypass (BYPASS=1).
//   - Per-register pending scoreboard: issue sets, commit clears, an issue
//     and a commit to the same register on one edge leave it pending.
//   - Registered trace of every committed write, one cycle after the edge.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset, clears all state
//   bus   : grf_mp_if.slave (read ports, write, issue, trace)
module grf_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int BYPASS = 1
) (
    input  logic    clk,
    input  logic    reset,
    grf_mp_if.slave bus
);
    localparam int                DEPTH  = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_A = {ADDR_W{1'b0}};
    localparam logic [DATA_W-1:0] ZERO_D = {DATA_W{1'b0}};
    localparam logic [DEPTH-1:0]  ZERO_S = {DEPTH{1'b0}};
    localparam logic [DEPTH-1:0]  ONE_S  = {{(DEPTH-1){1'b0}}, 1'b1};

    // True for any register other than the hard-wired zero register.
    function automatic logic live_addr(input logic [ADDR_W-1:0] a);
        return (a != ZERO_A);
    endfunction

    logic [DATA_W-1:0] regs_r [DEPTH];
    logic [DEPTH-1:0]  sb_r;
    logic [DEPTH-1:0]  sb_clr_s;
    logic [DEPTH-1:0]  sb_set_s;
    logic [DEPTH-1:0]  sb_nxt_s;
    logic              wr_hit_s;
    logic              iss_hit_s;
    logic              trace_valid_r;
    logic [ADDR_W-1:0] trace_addr_r;
    logic [DATA_W-1:0] trace_data_r;

    // Requests are qualified with reset so nothing (including the bypass
    // path) leaks through while the file is held in reset.
    assign wr_hit_s  = reset & bus.we & live_addr(bus.wa);
    assign iss_hit_s = reset & bus.iss_en & live_addr(bus.iss_addr);

    // Scoreboard next state: commit clears first, then issue sets, so a newer producer wins.
    always_comb begin
        sb_clr_s = wr_hit_s  ? (ONE_S << bus.wa)       : ZERO_S;
        sb_set_s = iss_hit_s ? (ONE_S << bus.iss_addr) : ZERO_S;
        sb_nxt_s = (sb_r & ~sb_clr_s) | sb_set_s;
    end

    // Pending scoreboard register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sb_r <= ZERO_S;
        end else begin
            sb_r <= sb_nxt_s;
        end
    end

    // Register storage; entry 0 is never written and therefore stays zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_r[i] <= ZERO_D;
            end
        end else if (wr_hit_s) begin
            regs_r[bus.wa] <= bus.wd;
        end
    end

    // Commit trace: valid pulses every committing edge, addr/data hold otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            trace_valid_r <= 1'b0;
            trace_addr_r  <= ZERO_A;
            trace_data_r  <= ZERO_D;
        end else begin
            trace_valid_r <= wr_hit_s;
            if (wr_hit_s) begin
                trace_addr_r <= bus.wa;
                trace_data_r <= bus.wd;
            end
        end
    end

    assign bus.trace_valid = trace_valid_r;
    assign bus.trace_addr  = trace_addr_r;
    assign bus.trace_data  = trace_data_r;

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [ADDR_W-1:0] ra_s;
        logic [DATA_W-1:0] d_s;
        logic              b_s;

        assign ra_s = bus.rd_addr[g*ADDR_W +: ADDR_W];

        // Read mux: zero register, then same-cycle bypass, then stored value and pending bit.
        always_comb begin
            d_s = ZERO_D;
            b_s = 1'b0;
            if (!live_addr(ra_s)) begin
                d_s = ZERO_D;
                b_s = 1'b0;
            end else if ((BYPASS != 0) && wr_hit_s && (bus.wa == ra_s)) begin
                d_s = bus.wd;
                b_s = 1'b0;
            end else begin
                d_s = regs_r[ra_s];
                b_s = sb_r[ra_s];
            end
        end

        assign bus.rd_data[g*DATA_W +: DATA_W] = d_s;
        assign bus.rd_busy[g]                  = b_s;
    end
endmodule
